// File: rtl/c2h_pkg.sv
// Shared widths, keep-mask helpers and ingress state encoding for the C2H packer.
package c2h_pkg;
    localparam int LEN_W    = 16;
    localparam int MTY_W    = 6;
    localparam int QID_W    = 11;
    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } ing_state_t;

    function automatic logic [LEN_W-1:0] keep_to_cnt(input logic [KEEP_MAX-1:0] keep);
        logic [LEN_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + {{(LEN_W-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

    // A mask of the form 2^k-1 has no set bit above a clear one.
    function automatic logic keep_contig(input logic [KEEP_MAX-1:0] keep);
        return (keep & (keep + KEEP_MAX'(1))) == '0;
    endfunction
endpackage

// File: rtl/c2h_sync_fifo.sv
// Synchronous FIFO with registered read and a committed write pointer that
// hides uncommitted entries from the reader and supports rewinding to it.
module c2h_sync_fifo
    import c2h_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             rewind,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      cmt_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic             wr_ok;

    assign wr_ok      = wr_en && !full;
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_ok};
    assign full       = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign empty      = (cmt_ptr == rd_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= cmt_ptr;
            end else begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (commit) begin
                cmt_ptr <= wr_ptr_nxt;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end
endmodule

// File: rtl/qdma_c2h_packer.sv
// Store-and-forward AXI-Stream to QDMA C2H converter: buffers whole packets,
// drops malformed/overflowing ones and presents length and mty with the beats.
module qdma_c2h_packer
    import c2h_pkg::*;
#(
    parameter int               DATA_W     = 512,
    parameter int               BEAT_DEPTH = 64,
    parameter int               PKT_DEPTH  = 8,
    parameter logic [QID_W-1:0] QID        = 11'd0
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser_err,
    output logic [DATA_W-1:0]     m_axis_c2h_tdata,
    output logic                  m_axis_c2h_tvalid,
    input  logic                  m_axis_c2h_tready,
    output logic                  m_axis_c2h_tlast,
    output logic [MTY_W-1:0]      m_axis_c2h_mty,
    output logic [LEN_W-1:0]      m_axis_c2h_ctrl_len,
    output logic [QID_W-1:0]      m_axis_c2h_ctrl_qid,
    output logic [31:0]           drop_cnt
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int BYTE_SH = $clog2(KEEP_W);
    localparam int PKT_CW  = $clog2(PKT_DEPTH) + 1;

    ing_state_t          state, state_nxt;
    logic                acc, first, pkt_full;
    logic                beat_full, beat_empty, desc_full, desc_empty;
    logic [KEEP_MAX-1:0] keep_ext;
    logic [LEN_W-1:0]    beat_bytes;
    logic [LEN_W:0]      len_sum;
    logic                keep_bad, bad_now;
    logic                wr_en, commit, rewind, drop_ev;
    logic [PKT_CW-1:0]   pkt_cnt;
    logic [LEN_W-1:0]    len_acc_p0;
    logic                bad_sticky_p0;
    logic                out_vld_p1;
    logic [LEN_W:0]      beat_idx_p1;
    logic [LEN_W-1:0]    cur_len;
    logic [LEN_W:0]      nbeats;
    logic                out_last, out_fire, advance, pkt_start, pkt_cont, pkt_pop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [MTY_W-1:0] mty_of(input logic [LEN_W-1:0] len);
        return MTY_W'(KEEP_W - int'(len[BYTE_SH-1:0]));
    endfunction

    assign keep_ext   = KEEP_MAX'(s_axis_tkeep);
    assign beat_bytes = keep_to_cnt(keep_ext);
    assign first      = (state == ST_IDLE);
    assign len_sum    = {1'b0, (first ? {LEN_W{1'b0}} : len_acc_p0)} + {1'b0, beat_bytes};
    assign keep_bad   = s_axis_tlast ? (!keep_contig(keep_ext) || (s_axis_tkeep == '0))
                                     : (s_axis_tkeep != '1);
    assign bad_now    = s_axis_tuser_err || keep_bad || len_sum[LEN_W] || (!first && bad_sticky_p0);

    assign pkt_full      = (pkt_cnt == PKT_CW'(PKT_DEPTH)) || desc_full;
    assign s_axis_tready = axis_aresetn && !(state == ST_IDLE && pkt_full);
    assign acc           = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_RECV: begin
                if (acc) begin
                    if (s_axis_tlast)   state_nxt = ST_IDLE;
                    else if (beat_full) state_nxt = ST_DISCARD;
                    else                state_nxt = ST_RECV;
                end
            end
            ST_DISCARD: if (acc && s_axis_tlast) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // A full beat FIFO or a bad last beat both discard the partial packet.
    always_comb begin
        wr_en   = 1'b0;
        commit  = 1'b0;
        rewind  = 1'b0;
        drop_ev = 1'b0;
        if (acc && state != ST_DISCARD) begin
            if (beat_full || (s_axis_tlast && bad_now)) begin
                rewind  = 1'b1;
                drop_ev = 1'b1;
            end else begin
                wr_en  = 1'b1;
                commit = s_axis_tlast;
            end
        end
    end

    // Ingress stage p0: running length and sticky error of the packet in flight
    always_ff @(posedge axis_aclk) begin
        if (acc && state != ST_DISCARD) begin
            len_acc_p0    <= len_sum[LEN_W-1:0];
            bad_sticky_p0 <= bad_now;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            drop_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (drop_ev) drop_cnt <= sat_inc(drop_cnt);
            case ({commit, pkt_pop})
                2'b10:   pkt_cnt <= pkt_cnt + PKT_CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PKT_CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    c2h_sync_fifo #(.WIDTH(DATA_W), .DEPTH(BEAT_DEPTH)) u_beat_fifo (
        .clk     (axis_aclk),
        .rst_n   (axis_aresetn),
        .wr_en   (wr_en),
        .wr_data (s_axis_tdata),
        .commit  (commit),
        .rewind  (rewind),
        .rd_en   (pkt_start || pkt_cont),
        .rd_data (m_axis_c2h_tdata),
        .full    (beat_full),
        .empty   (beat_empty)
    );

    c2h_sync_fifo #(.WIDTH(LEN_W), .DEPTH(PKT_DEPTH)) u_desc_fifo (
        .clk     (axis_aclk),
        .rst_n   (axis_aresetn),
        .wr_en   (commit),
        .wr_data (len_sum[LEN_W-1:0]),
        .commit  (1'b1),
        .rewind  (1'b0),
        .rd_en   (pkt_start),
        .rd_data (cur_len),
        .full    (desc_full),
        .empty   (desc_empty)
    );

    assign nbeats    = ({1'b0, cur_len} + (LEN_W+1)'(KEEP_W - 1)) >> BYTE_SH;
    assign out_last  = out_vld_p1 && (beat_idx_p1 == nbeats);
    assign out_fire  = out_vld_p1 && m_axis_c2h_tready;
    assign advance   = !out_vld_p1 || out_fire;
    assign pkt_start = advance && (!out_vld_p1 || out_last) && !desc_empty && !beat_empty;
    assign pkt_cont  = advance && out_vld_p1 && !out_last;
    assign pkt_pop   = out_fire && out_last;

    // Egress stage p1: output register fed by the registered FIFO reads
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            out_vld_p1  <= 1'b0;
            beat_idx_p1 <= '0;
        end else if (advance) begin
            out_vld_p1 <= pkt_start || pkt_cont;
            if (pkt_start)     beat_idx_p1 <= (LEN_W+1)'(1);
            else if (pkt_cont) beat_idx_p1 <= beat_idx_p1 + (LEN_W+1)'(1);
        end
    end

    assign m_axis_c2h_tvalid   = out_vld_p1;
    assign m_axis_c2h_tlast    = out_last;
    assign m_axis_c2h_mty      = out_last ? mty_of(cur_len) : '0;
    assign m_axis_c2h_ctrl_len = out_vld_p1 ? cur_len : '0;
    assign m_axis_c2h_ctrl_qid = QID;
endmodule
